// File: rtl/xbtnread_pkg.sv
// Shared definitions for the pushbutton read peripheral: bus width and
// the bit positions of each field in the read word.
package xbtnread_pkg;

  localparam int DATA_W    = 32;
  localparam int LEVEL_BIT = 0;
  localparam int FLAG_BIT  = 1;
  localparam int CNT_LSB   = 8;

  typedef logic [DATA_W-1:0] data_t;

endpackage : xbtnread_pkg

// File: rtl/xdebounce.sv
// Two-flop synchronizer followed by a four-state debounce FSM. Emits the
// debounced level and a one-cycle pulse on each qualified press.
module xdebounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_param
      $error("xdebounce: DEBOUNCE_CYCLES out of range 2..65535");
    end
  endgenerate

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } state_t;

  logic [1:0]    sync_q, sync_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_s;

  assign sync_d = {sync_q[0], btn};
  assign btn_s  = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter only advances while strictly below CNT_LAST, so it cannot wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press   = 1'b0;
    case (state_q)
      RELEASED: begin
        if (btn_s) begin
          state_d = PRESS_PEND;
          cnt_d   = '0;
        end
      end
      PRESS_PEND: begin
        if (!btn_s) begin
          state_d = RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          press   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = RELEASE_PEND;
          cnt_d   = '0;
        end
      end
      RELEASE_PEND: begin
        if (btn_s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign level = (state_q == PRESSED) || (state_q == RELEASE_PEND);

endmodule : xdebounce

// File: rtl/xbtnread.sv
// Pushbutton read peripheral: debounced level, sticky press flag and a
// saturating press counter, all cleared by a processor read.
module xbtnread
  import xbtnread_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              btn,
  output logic [DATA_W-1:0] data_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  generate
    if (CNT_W < 1 || CNT_LSB + CNT_W > DATA_W) begin : g_bad_param
      $error("xbtnread: CNT_W does not fit in the read word");
    end
  endgenerate

  logic             level;
  logic             press;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  xdebounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .level(level),
    .press(press)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  // A press landing on a read cycle is not lost: it becomes the first
  // event of the next reporting window.
  always_comb begin
    flag_d = sel ? 1'b0 : flag_q;
    cnt_d  = sel ? '0 : cnt_q;
    if (press) begin
      flag_d = 1'b1;
      if (sel) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    data_out = '0;
    if (sel) begin
      data_out[LEVEL_BIT]         = level;
      data_out[FLAG_BIT]          = flag_q;
      data_out[CNT_LSB +: CNT_W]  = cnt_q;
    end
  end

endmodule : xbtnread

// File: doc/xbtnread.md
XBTNREAD -- requirements
Module: xbtnread

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000, number of consecutive stable synchronized samples required to accept a level change; legal range 2..65535.
REQ-002 Parameter CNT_W, default 8, width of the press-event counter.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sel  input  1  peripheral select from the address decoder; one-cycle read strobe per processor access.
REQ-006 btn  input  1  raw, asynchronous, bouncing pushbutton level (1 = pressed).
REQ-007 data_out  output  DATA_W  read data to the processor; DATA_W from the shared defines.

Function
REQ-008 btn SHALL pass through a 2-flop synchronizer; only the second flop output (btn_s) feeds the logic.
REQ-009 Debounce FSM states SHALL be RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
REQ-010 RELEASED: btn_s=1 -> PRESS_PEND, stable counter cleared to 0.
REQ-011 PRESS_PEND: btn_s=0 -> RELEASED; btn_s=1 and counter=DEBOUNCE_CYCLES-1 -> PRESSED plus one-cycle press event; otherwise counter+1.
REQ-012 PRESSED: btn_s=0 -> RELEASE_PEND, counter cleared.
REQ-013 RELEASE_PEND: btn_s=1 -> PRESSED with no new event; btn_s=0 and counter=DEBOUNCE_CYCLES-1 -> RELEASED; otherwise counter+1.
REQ-014 Stable counter width SHALL be clog2(DEBOUNCE_CYCLES) and SHALL never wrap.
REQ-015 Latency: btn rising sampled at edge k -> debounced level 1 after edge k+2+DEBOUNCE_CYCLES when the input stays stable; release is symmetric.
REQ-016 Debounced level SHALL be 1 in PRESSED and RELEASE_PEND, and 0 otherwise.
REQ-017 Sticky flag SHALL set on each press event.
REQ-018 Press counter (CNT_W bits) SHALL increment on each press event and saturate at 2^CNT_W-1.
REQ-019 data_out layout: bit0 debounced level; bit1 sticky flag; bits [8+CNT_W-1:8] press count; all other bits 0.
REQ-020 data_out SHALL be combinational from registered state when sel=1, and all-zero when sel=0 (OR-able read bus).
REQ-021 Clear-on-read: each cycle with sel=1 SHALL return the current values and clear the sticky flag and press count at that clock edge.
REQ-022 A press event in the same cycle as sel=1 SHALL win: the read returns the pre-event values, and the next state is flag=1, count=1.
REQ-023 Glitches shorter than DEBOUNCE_CYCLES cycles on btn_s SHALL produce no event and no level change.

Reset
REQ-024 rst=1 SHALL immediately force synchronizer flops to 0, FSM to RELEASED, stable counter, sticky flag and press count to 0, and data_out to 0.
REQ-025 Reset asserted mid-debounce or mid-press SHALL discard pending state; after release a still-held btn SHALL be re-qualified from RELEASED and counted as a new press.

Structure
REQ-026 The DATA_W define and the bit-field positions (level, flag, count LSB) SHALL live in the shared defines file; FSM state encodings stay local.
REQ-027 The synchronizer plus debounce FSM SHALL be one sub-module, xdebounce (outputs level and press pulse); xbtnread adds flag, counter and read logic.

Verification (DEBOUNCE_CYCLES=4, CNT_W=8)
REQ-028 Clean press held 20 cycles -> bit0=1 exactly 6 cycles after the first sampled high; read returns 0x00000103; the following read returns 0x00000001.
REQ-029 Bounce of three 2-cycle pulses, then release -> no event; read returns 0x00000000.
REQ-030 300 clean presses with no read -> count saturates; read returns 0x0000FF02 (released) then 0x00000000.
REQ-031 Press event coincident with sel -> that read returns 0x00000000; next read returns 0x00000103 (or 0x00000102 if released).
REQ-032 rst pulsed while PRESS_PEND and again while PRESSED with btn held -> outputs 0 during reset; one new event 6 cycles after deassertion.
REQ-033 sel=0 throughout any activity -> data_out stays 0x00000000.
